// File: rtl/alu_issue_scheduler_if.sv
// Purpose : bundles the dispatch, result-broadcast and issue signals of
//           alu_issue_scheduler into one port.
// Ports   : master = dispatch/broadcast/flush driver side; slave = scheduler side.
interface alu_issue_scheduler_if;
  // synchronous queue clear
  logic        flush;

  // dispatch request
  logic        disp_valid;
  logic        disp_ready;
  logic [3:0]  disp_alu_control;
  logic [31:0] disp_tag_a;
  logic [31:0] disp_tag_b;
  logic [31:0] disp_data_a;
  logic [31:0] disp_data_b;
  logic        disp_rdy_a;
  logic        disp_rdy_b;
  logic [31:0] disp_dest;

  // result broadcast from ALU0 / ALU1
  logic [31:0] dest0;
  logic [31:0] dest1;
  logic [31:0] alu_out0;
  logic [31:0] alu_out1;
  logic        reg_write0;
  logic        reg_write1;

  // registered issue slots
  logic [3:0]  d0_alu_control;
  logic [3:0]  d1_alu_control;
  logic [31:0] d0_src_a;
  logic [31:0] d0_src_b;
  logic [31:0] d1_src_a;
  logic [31:0] d1_src_b;
  logic [31:0] d0_dest;
  logic [31:0] d1_dest;
  logic        d0_reg_write;
  logic        d1_reg_write;

  // occupancy
  logic [2:0]  count;

  modport master (
    output flush, disp_valid, disp_alu_control, disp_tag_a, disp_tag_b,
           disp_data_a, disp_data_b, disp_rdy_a, disp_rdy_b, disp_dest,
           dest0, dest1, alu_out0, alu_out1, reg_write0, reg_write1,
    input  disp_ready, d0_alu_control, d1_alu_control, d0_src_a, d0_src_b,
           d1_src_a, d1_src_b, d0_dest, d1_dest, d0_reg_write, d1_reg_write,
           count
  );

  modport slave (
    input  flush, disp_valid, disp_alu_control, disp_tag_a, disp_tag_b,
           disp_data_a, disp_data_b, disp_rdy_a, disp_rdy_b, disp_dest,
           dest0, dest1, alu_out0, alu_out1, reg_write0, reg_write1,
    output disp_ready, d0_alu_control, d1_alu_control, d0_src_a, d0_src_b,
           d1_src_a, d1_src_b, d0_dest, d1_dest, d0_reg_write, d1_reg_write,
           count
  );
endinterface

// File: rtl/alu_issue_scheduler.sv
// Purpose : 4-entry age-ordered ALU reservation queue with tag wakeup,
//           issuing the oldest ready entries onto two registered ALU slots.
// Latency : dispatch with both operands ready at t -> selected t+1 -> D0 valid t+2.
// Backpressure: disp_ready = registered count < 4; issue never frees a slot the
//           same cycle.
// Ports   : clk, rst_n (async active-low), bus (alu_issue_scheduler_if.slave).
// Config  : DUAL_ISSUE_EN defined -> ALU0 and ALU1 both issue each cycle;
//           undefined -> only ALU0 issues, all D1 outputs tied to 0.
module alu_issue_scheduler (
  input  logic                  clk,
  input  logic                  rst_n,
  alu_issue_scheduler_if.slave  bus
);

  localparam int DEPTH = 4;

`ifdef DUAL_ISSUE_EN
  localparam bit DUAL = 1'b1;
`else
  localparam bit DUAL = 1'b0;
`endif

  typedef struct packed {
    logic        valid;
    logic [3:0]  ctl;
    logic        rdy_a;
    logic        rdy_b;
    logic [31:0] tag_a;
    logic [31:0] tag_b;
    logic [31:0] data_a;
    logic [31:0] data_b;
    logic [31:0] dest;
  } entry_t;

  entry_t      q     [DEPTH];
  entry_t      q_nxt [DEPTH];
  entry_t      disp_ent;
  logic [2:0]  count_q;
  logic [2:0]  count_nxt;
  logic [2:0]  wr_idx;
  logic [DEPTH-1:0] ready;
  logic [DEPTH-1:0] issued;
  logic        sel0_vld;
  logic        sel1_vld;
  logic [1:0]  sel0_idx;
  logic [1:0]  sel1_idx;
  logic        issue1;
  logic        disp_fire;

  logic        d0_rw_q;
  logic [3:0]  d0_ctl_q;
  logic [31:0] d0_a_q;
  logic [31:0] d0_b_q;
  logic [31:0] d0_dest_q;

  // Operand capture from the broadcast buses; ALU0 has priority when both
  // ports carry the same tag.
  function automatic entry_t wake(
    input entry_t      e,
    input logic        rw0,
    input logic [31:0] t0,
    input logic [31:0] v0,
    input logic        rw1,
    input logic [31:0] t1,
    input logic [31:0] v1
  );
    entry_t r;
    r = e;
    if (!e.rdy_a) begin
      if (rw0 && (t0 == e.tag_a)) begin
        r.rdy_a  = 1'b1;
        r.data_a = v0;
      end else if (rw1 && (t1 == e.tag_a)) begin
        r.rdy_a  = 1'b1;
        r.data_a = v1;
      end
    end
    if (!e.rdy_b) begin
      if (rw0 && (t0 == e.tag_b)) begin
        r.rdy_b  = 1'b1;
        r.data_b = v0;
      end else if (rw1 && (t1 == e.tag_b)) begin
        r.rdy_b  = 1'b1;
        r.data_b = v1;
      end
    end
    return r;
  endfunction

  assign bus.disp_ready = (count_q < 3'd4);
  assign bus.count      = count_q;
  assign disp_fire      = bus.disp_valid && (count_q < 3'd4) && !bus.flush;

  // Readiness uses registered flags only, so a wakeup captured at an edge
  // becomes selectable one cycle later.
  always_comb begin
    ready = '0;
    for (int i = 0; i < DEPTH; i++) begin
      ready[i] = q[i].valid && q[i].rdy_a && q[i].rdy_b;
    end
  end

  // Oldest ready entry goes to ALU0, the next-oldest to ALU1.
  always_comb begin
    sel0_vld = 1'b0;
    sel1_vld = 1'b0;
    sel0_idx = 2'd0;
    sel1_idx = 2'd0;
    for (int i = 0; i < DEPTH; i++) begin
      if (ready[i]) begin
        if (!sel0_vld) begin
          sel0_vld = 1'b1;
          sel0_idx = 2'(i);
        end else if (!sel1_vld) begin
          sel1_vld = 1'b1;
          sel1_idx = 2'(i);
        end
      end
    end
  end

  assign issue1 = sel1_vld && DUAL;

  always_comb begin
    issued = '0;
    if (sel0_vld) issued[sel0_idx] = 1'b1;
    if (issue1)   issued[sel1_idx] = 1'b1;
  end

  always_comb begin
    disp_ent        = '0;
    disp_ent.valid  = 1'b1;
    disp_ent.ctl    = bus.disp_alu_control;
    disp_ent.rdy_a  = bus.disp_rdy_a;
    disp_ent.rdy_b  = bus.disp_rdy_b;
    disp_ent.tag_a  = bus.disp_tag_a;
    disp_ent.tag_b  = bus.disp_tag_b;
    disp_ent.data_a = bus.disp_data_a;
    disp_ent.data_b = bus.disp_data_b;
    disp_ent.dest   = bus.disp_dest;
  end

  // Compaction: survivors slide down in age order, then the new dispatch is
  // appended behind them. Count < 4 whenever disp_fire, so wr_idx stays in range.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      q_nxt[i] = '0;
    end
    wr_idx = 3'd0;
    for (int i = 0; i < DEPTH; i++) begin
      if (q[i].valid && !issued[i]) begin
        q_nxt[wr_idx[1:0]] = wake(q[i], bus.reg_write0, bus.dest0, bus.alu_out0,
                                  bus.reg_write1, bus.dest1, bus.alu_out1);
        wr_idx = wr_idx + 3'd1;
      end
    end
    if (disp_fire) begin
      q_nxt[wr_idx[1:0]] = wake(disp_ent, bus.reg_write0, bus.dest0, bus.alu_out0,
                                bus.reg_write1, bus.dest1, bus.alu_out1);
    end
  end

  assign count_nxt = count_q + 3'(disp_fire) - 3'(sel0_vld) - 3'(issue1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        q[i] <= '0;
      end
      count_q   <= 3'd0;
      d0_rw_q   <= 1'b0;
      d0_ctl_q  <= 4'd0;
      d0_a_q    <= 32'd0;
      d0_b_q    <= 32'd0;
      d0_dest_q <= 32'd0;
    end else if (bus.flush) begin
      // Flush overrides dispatch, issue and wakeup; issue data simply holds.
      for (int i = 0; i < DEPTH; i++) begin
        q[i].valid <= 1'b0;
        q[i].rdy_a <= 1'b0;
        q[i].rdy_b <= 1'b0;
      end
      count_q <= 3'd0;
      d0_rw_q <= 1'b0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        q[i] <= q_nxt[i];
      end
      count_q <= count_nxt;
      d0_rw_q <= sel0_vld;
      if (sel0_vld) begin
        d0_ctl_q  <= q[sel0_idx].ctl;
        d0_a_q    <= q[sel0_idx].data_a;
        d0_b_q    <= q[sel0_idx].data_b;
        d0_dest_q <= q[sel0_idx].dest;
      end
    end
  end

  assign bus.d0_reg_write   = d0_rw_q;
  assign bus.d0_alu_control = d0_ctl_q;
  assign bus.d0_src_a       = d0_a_q;
  assign bus.d0_src_b       = d0_b_q;
  assign bus.d0_dest        = d0_dest_q;

`ifdef DUAL_ISSUE_EN
  logic        d1_rw_q;
  logic [3:0]  d1_ctl_q;
  logic [31:0] d1_a_q;
  logic [31:0] d1_b_q;
  logic [31:0] d1_dest_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      d1_rw_q   <= 1'b0;
      d1_ctl_q  <= 4'd0;
      d1_a_q    <= 32'd0;
      d1_b_q    <= 32'd0;
      d1_dest_q <= 32'd0;
    end else if (bus.flush) begin
      d1_rw_q <= 1'b0;
    end else begin
      d1_rw_q <= issue1;
      if (issue1) begin
        d1_ctl_q  <= q[sel1_idx].ctl;
        d1_a_q    <= q[sel1_idx].data_a;
        d1_b_q    <= q[sel1_idx].data_b;
        d1_dest_q <= q[sel1_idx].dest;
      end
    end
  end

  assign bus.d1_reg_write   = d1_rw_q;
  assign bus.d1_alu_control = d1_ctl_q;
  assign bus.d1_src_a       = d1_a_q;
  assign bus.d1_src_b       = d1_b_q;
  assign bus.d1_dest        = d1_dest_q;
`else
  assign bus.d1_reg_write   = 1'b0;
  assign bus.d1_alu_control = 4'd0;
  assign bus.d1_src_a       = 32'd0;
  assign bus.d1_src_b       = 32'd0;
  assign bus.d1_dest        = 32'd0;
`endif

endmodule

// File: tb/tb_alu_issue_scheduler.sv
// Purpose : self-checking bench for alu_issue_scheduler against a queue-based
//           reference model; directed scenarios followed by random traffic.
// Ports   : none (top level); instantiates alu_issue_scheduler_if and the DUT.
module tb_alu_issue_scheduler;

`ifdef DUAL_ISSUE_EN
  localparam bit DUAL = 1'b1;
`else
  localparam bit DUAL = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  alu_issue_scheduler_if bus ();

  alu_issue_scheduler dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Reference model: an ordinary queue, index 0 = oldest.
  typedef struct {
    logic [3:0]  ctl;
    bit          ra;
    bit          rb;
    logic [31:0] ta;
    logic [31:0] tbg;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] dest;
  } ment_t;

  ment_t       mq[$];
  bit          e_d0_rw;
  bit          e_d1_rw;
  logic [99:0] e_d0;
  logic [99:0] e_d1;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
  endtask

  function automatic ment_t wake(input ment_t e);
    ment_t r = e;
    if (!r.ra) begin
      if (bus.reg_write0 && bus.dest0 == r.ta) begin r.ra = 1; r.a = bus.alu_out0; end
      else if (bus.reg_write1 && bus.dest1 == r.ta) begin r.ra = 1; r.a = bus.alu_out1; end
    end
    if (!r.rb) begin
      if (bus.reg_write0 && bus.dest0 == r.tbg) begin r.rb = 1; r.b = bus.alu_out0; end
      else if (bus.reg_write1 && bus.dest1 == r.tbg) begin r.rb = 1; r.b = bus.alu_out1; end
    end
    return r;
  endfunction

  task automatic model_reset();
    mq.delete();
    e_d0_rw = 0;
    e_d1_rw = 0;
    e_d0    = '0;
    e_d1    = '0;
  endtask

  // Applies one clock edge to the model using the inputs present at the edge.
  task automatic model_step();
    int    i0 = -1;
    int    i1 = -1;
    bit    acc;
    ment_t ne;
    if (bus.flush) begin
      mq.delete();
      e_d0_rw = 0;
      e_d1_rw = 0;
      return;
    end
    foreach (mq[i]) begin
      if (mq[i].ra && mq[i].rb) begin
        if (i0 < 0) i0 = i;
        else if (i1 < 0 && DUAL) i1 = i;
      end
    end
    acc = bus.disp_valid && (mq.size() < 4);
    ne.ctl  = bus.disp_alu_control;
    ne.ra   = bus.disp_rdy_a;
    ne.rb   = bus.disp_rdy_b;
    ne.ta   = bus.disp_tag_a;
    ne.tbg  = bus.disp_tag_b;
    ne.a    = bus.disp_data_a;
    ne.b    = bus.disp_data_b;
    ne.dest = bus.disp_dest;
    e_d0_rw = (i0 >= 0);
    e_d1_rw = (i1 >= 0);
    if (i0 >= 0) e_d0 = {mq[i0].ctl, mq[i0].a, mq[i0].b, mq[i0].dest};
    if (i1 >= 0) e_d1 = {mq[i1].ctl, mq[i1].a, mq[i1].b, mq[i1].dest};
    if (i1 >= 0) mq.delete(i1);
    if (i0 >= 0) mq.delete(i0);
    foreach (mq[k]) mq[k] = wake(mq[k]);
    if (acc) mq.push_back(wake(ne));
  endtask

  task automatic check_all();
    check("count",      128'(bus.count), 128'(mq.size()));
    check("disp_ready", 128'(bus.disp_ready), 128'(mq.size() < 4));
    check("d0_rw",      128'(bus.d0_reg_write), 128'(e_d0_rw));
    check("d0_dat",     128'({bus.d0_alu_control, bus.d0_src_a, bus.d0_src_b, bus.d0_dest}), 128'(e_d0));
    check("d1_rw",      128'(bus.d1_reg_write), 128'(e_d1_rw));
    check("d1_dat",     128'({bus.d1_alu_control, bus.d1_src_a, bus.d1_src_b, bus.d1_dest}), 128'(e_d1));
  endtask

  task automatic set_idle();
    bus.flush            = 0;
    bus.disp_valid       = 0;
    bus.disp_alu_control = '0;
    bus.disp_tag_a       = '0;
    bus.disp_tag_b       = '0;
    bus.disp_data_a      = '0;
    bus.disp_data_b      = '0;
    bus.disp_rdy_a       = 0;
    bus.disp_rdy_b       = 0;
    bus.disp_dest        = '0;
    bus.dest0            = '0;
    bus.dest1            = '0;
    bus.alu_out0         = '0;
    bus.alu_out1         = '0;
    bus.reg_write0       = 0;
    bus.reg_write1       = 0;
  endtask

  task automatic disp(input logic [3:0] ctl, input bit ra, input logic [31:0] ta_or_a,
                      input bit rb, input logic [31:0] tb_or_b, input logic [31:0] dest);
    bus.disp_valid       = 1;
    bus.disp_alu_control = ctl;
    bus.disp_rdy_a       = ra;
    bus.disp_rdy_b       = rb;
    bus.disp_tag_a       = ra ? 32'hFFFF_0000 : ta_or_a;
    bus.disp_tag_b       = rb ? 32'hFFFF_0001 : tb_or_b;
    bus.disp_data_a      = ra ? ta_or_a : 32'hDEAD_0000;
    bus.disp_data_b      = rb ? tb_or_b : 32'hDEAD_0001;
    bus.disp_dest        = dest;
  endtask

  task automatic bcast0(input logic [31:0] tag, input logic [31:0] val);
    bus.reg_write0 = 1; bus.dest0 = tag; bus.alu_out0 = val;
  endtask

  task automatic bcast1(input logic [31:0] tag, input logic [31:0] val);
    bus.reg_write1 = 1; bus.dest1 = tag; bus.alu_out1 = val;
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    check_all();
    set_idle();
  endtask

  task automatic rand_inputs();
    bus.flush            = ($urandom_range(0, 24) == 0);
    bus.disp_valid       = ($urandom_range(0, 9) < 6);
    bus.disp_alu_control = 4'($urandom);
    bus.disp_rdy_a       = $urandom_range(0, 1) == 1;
    bus.disp_rdy_b       = $urandom_range(0, 1) == 1;
    bus.disp_tag_a       = $urandom_range(0, 7);
    bus.disp_tag_b       = $urandom_range(0, 7);
    bus.disp_data_a      = $urandom;
    bus.disp_data_b      = $urandom;
    bus.disp_dest        = $urandom_range(0, 7);
    bus.reg_write0       = $urandom_range(0, 1) == 1;
    bus.reg_write1       = $urandom_range(0, 1) == 1;
    bus.dest0            = $urandom_range(0, 7);
    bus.dest1            = $urandom_range(0, 7);
    bus.alu_out0         = $urandom;
    bus.alu_out1         = $urandom;
  endtask

  initial begin
    rst_n = 0;
    set_idle();
    model_reset();
    #12;
    check_all();
    rst_n = 1;

    // Both operands ready: issue visible two edges after dispatch.
    disp(4'd2, 1, 32'd5, 1, 32'd7, 32'd9);
    tick(); tick(); tick();

    // Operand A waits on tag 3, supplied later by ALU1.
    disp(4'd1, 0, 32'd3, 1, 32'd4, 32'd11);
    tick(); tick();
    bcast1(32'd3, 32'h10);
    tick(); tick(); tick();

    // Wakeup arriving in the dispatch cycle itself.
    disp(4'd3, 0, 32'd6, 1, 32'd8, 32'd12);
    bcast0(32'd6, 32'h55);
    tick(); tick(); tick();

    // Both ports broadcast the same tag: ALU0 value must win.
    disp(4'd4, 0, 32'd40, 0, 32'd40, 32'd13);
    tick();
    bcast0(32'd40, 32'hAAAA); bcast1(32'd40, 32'hBBBB);
    tick(); tick(); tick();

    // Fill the queue, try an extra dispatch, then wake everything.
    for (int k = 0; k < 4; k++) begin
      disp(4'(k + 5), 0, 32'(20 + k), 1, 32'(100 + k), 32'(50 + k));
      tick();
    end
    disp(4'hF, 1, 32'd1, 1, 32'd2, 32'd77);
    tick();
    bcast0(32'd20, 32'h200); bcast1(32'd21, 32'h210);
    tick();
    bcast0(32'd22, 32'h220); bcast1(32'd23, 32'h230);
    tick();
    for (int k = 0; k < 5; k++) tick();

    // Flush with three queued entries and a simultaneous dispatch.
    for (int k = 0; k < 3; k++) begin
      disp(4'd1, 0, 32'(30 + k), 1, 32'd0, 32'(60 + k));
      tick();
    end
    bus.flush = 1;
    disp(4'd2, 1, 32'd1, 1, 32'd1, 32'd1);
    tick(); tick();

    // Two ready entries back to back.
    disp(4'd6, 1, 32'd61, 1, 32'd62, 32'd63);
    tick();
    disp(4'd7, 1, 32'd71, 1, 32'd72, 32'd73);
    tick(); tick(); tick(); tick();

    // Random traffic.
    for (int c = 0; c < 400; c++) begin
      rand_inputs();
      tick();
    end

    // Asynchronous reset in the middle of a busy queue.
    for (int c = 0; c < 6; c++) begin
      rand_inputs();
      bus.flush = 0;
      tick();
    end
    #2 rst_n = 0;
    #1;
    model_reset();
    check_all();
    rst_n = 1;

    for (int c = 0; c < 300; c++) begin
      rand_inputs();
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
